lemming_world: RTL and testbench

Terrain and physics model driven by the lemming walker FSM: it consumes the walker's Moore outputs (walk_left, walk_right, aaah, digging) and produces its environment inputs (bump_left, bump_right, ground). It tracks the lemming's column and level, moves it, drops it down holes, and removes ground under it while it digs. It closes the loop with the walker FSM in self-checking benches and in the demo top.

---
 rtl/lemming_pkg.sv | 50 +++++
 rtl/lemming_terrain.sv | 70 +++++++
 rtl/lemming_world.sv | 134 +++++++++++++
 tb/tb_lemming_world.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lemming_pkg.sv
// Shared constants, widths and encodings for the lemming terrain model.
package lemming_pkg;

    localparam int WIDTH      = 16;
    localparam int DEPTH      = 7;
    localparam int DIG_CYCLES = 4;
    localparam int START_POS  = 8;

    localparam int POS_W = $clog2(WIDTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    // Walker FSM state encoding, shared by the walker and the world model.
    typedef enum logic [2:0] {
        WS_WALK_L = 3'd0,
        WS_WALK_R = 3'd1,
        WS_FALL_L = 3'd2,
        WS_FALL_R = 3'd3,
        WS_DIG_L  = 3'd4,
        WS_DIG_R  = 3'd5,
        WS_SPLAT  = 3'd6
    } walker_state_e;

    // The single walker request acted upon in a cycle.
    typedef enum logic [2:0] {
        ACT_IDLE  = 3'd0,
        ACT_FALL  = 3'd1,
        ACT_DIG   = 3'd2,
        ACT_LEFT  = 3'd3,
        ACT_RIGHT = 3'd4
    } action_e;

    // Resolve simultaneous walker outputs: aaah > digging > walk_left > walk_right.
    function automatic action_e pick_action(input logic aaah, input logic digging,
                                            input logic walk_left, input logic walk_right);
        action_e act;
        if (aaah) begin
            act = ACT_FALL;
        end else if (digging) begin
            act = ACT_DIG;
        end else if (walk_left) begin
            act = ACT_LEFT;
        end else if (walk_right) begin
            act = ACT_RIGHT;
        end else begin
            act = ACT_IDLE;
        end
        return act;
    endfunction

endpackage

// File: rtl/lemming_terrain.sv
// Per-column surface depth storage with config writes, dig increments and
// read ports for the lemming's column and its two neighbours.
module lemming_terrain import lemming_pkg::*; #(
    parameter int WIDTH = lemming_pkg::WIDTH,
    parameter int DEPTH = lemming_pkg::DEPTH,
    parameter int POS_W = $clog2(WIDTH),
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             cfg_we_i,
    input  logic [POS_W-1:0] cfg_col_i,
    input  logic [LVL_W-1:0] cfg_depth_i,
    input  logic             dig_inc_i,
    input  logic [POS_W-1:0] pos_i,
    input  logic [LVL_W-1:0] lvl_i,
    output logic [LVL_W-1:0] surf_here_o,
    output logic [LVL_W-1:0] surf_left_o,
    output logic [LVL_W-1:0] surf_right_o
);

    localparam logic [LVL_W-1:0] DEPTH_MAX = LVL_W'(DEPTH);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(WIDTH - 1);

    logic [LVL_W-1:0] surf_q [WIDTH];
    logic [LVL_W-1:0] surf_d [WIDTH];
    logic [LVL_W-1:0] cfg_clamped_s;
    logic             cfg_ok_s;

    // Clamp the requested depth and refuse writes that would bury the lemming.
    always_comb begin
        cfg_clamped_s = (cfg_depth_i > DEPTH_MAX) ? DEPTH_MAX : cfg_depth_i;
        cfg_ok_s      = cfg_we_i && !((cfg_col_i == pos_i) && (cfg_clamped_s < lvl_i));
    end

    // Next surface per column: an accepted config write beats a dig increment.
    always_comb begin
        for (int c = 0; c < WIDTH; c++) begin
            surf_d[c] = surf_q[c];
            if (cfg_ok_s && (cfg_col_i == POS_W'(c))) begin
                surf_d[c] = cfg_clamped_s;
            end else if (dig_inc_i && (pos_i == POS_W'(c)) && (surf_q[c] != DEPTH_MAX)) begin
                surf_d[c] = surf_q[c] + 1'b1;
            end else begin
                surf_d[c] = surf_q[c];
            end
        end
    end

    // Surface register array; reset flattens the terrain.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int c = 0; c < WIDTH; c++) begin
                surf_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < WIDTH; c++) begin
                surf_q[c] <= surf_d[c];
            end
        end
    end

    // Read ports; out-of-range neighbours read 0 and are masked by the caller.
    always_comb begin
        surf_here_o  = surf_q[pos_i];
        surf_left_o  = (pos_i == '0)      ? '0 : surf_q[pos_i - 1'b1];
        surf_right_o = (pos_i == POS_LAST) ? '0 : surf_q[pos_i + 1'b1];
    end

endmodule

// File: rtl/lemming_world.sv
// Environment model for the lemming walker: tracks column, level and dig
// progress, and reports ground and wall contact back to the walker.
module lemming_world import lemming_pkg::*; #(
    parameter int WIDTH      = lemming_pkg::WIDTH,
    parameter int DEPTH      = lemming_pkg::DEPTH,
    parameter int DIG_CYCLES = lemming_pkg::DIG_CYCLES,
    parameter int START_POS  = lemming_pkg::START_POS,
    parameter int POS_W      = $clog2(WIDTH),
    parameter int LVL_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             walk_left,
    input  logic             walk_right,
    input  logic             aaah,
    input  logic             digging,
    input  logic             cfg_we,
    input  logic [POS_W-1:0] cfg_col,
    input  logic [LVL_W-1:0] cfg_depth,
    output logic             bump_left,
    output logic             bump_right,
    output logic             ground,
    output logic [POS_W-1:0] pos,
    output logic [LVL_W-1:0] lvl
);

    localparam int               DIG_W     = (DIG_CYCLES > 1) ? $clog2(DIG_CYCLES) : 1;
    localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(DIG_CYCLES - 1);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(WIDTH - 1);
    localparam logic [POS_W-1:0] POS_RESET = POS_W'(START_POS);

    logic [POS_W-1:0] pos_q, pos_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [DIG_W-1:0] dig_q, dig_d;
    logic             dig_inc_s;
    logic             ground_s;
    logic             blocked_left_s;
    logic             blocked_right_s;
    logic [LVL_W-1:0] surf_here_s, surf_left_s, surf_right_s;
    action_e          act_s;

    lemming_terrain #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .POS_W (POS_W),
        .LVL_W (LVL_W)
    ) u_terrain (
        .clk          (clk),
        .areset_n     (areset_n),
        .cfg_we_i     (cfg_we),
        .cfg_col_i    (cfg_col),
        .cfg_depth_i  (cfg_depth),
        .dig_inc_i    (dig_inc_s),
        .pos_i        (pos_q),
        .lvl_i        (lvl_q),
        .surf_here_o  (surf_here_s),
        .surf_left_o  (surf_left_s),
        .surf_right_o (surf_right_s)
    );

    // Contact decode from registered position and terrain.
    always_comb begin
        ground_s        = (surf_here_s == lvl_q);
        blocked_left_s  = (pos_q == '0)      || (surf_left_s  < lvl_q);
        blocked_right_s = (pos_q == POS_LAST) || (surf_right_s < lvl_q);
        act_s           = pick_action(aaah, digging, walk_left, walk_right);
    end

    // Movement, fall and dig progress for the winning walker request.
    always_comb begin
        pos_d     = pos_q;
        lvl_d     = lvl_q;
        dig_d     = '0;
        dig_inc_s = 1'b0;
        case (act_s)
            ACT_FALL: begin
                if (!ground_s) begin
                    lvl_d = lvl_q + 1'b1;
                end else begin
                    lvl_d = lvl_q;
                end
            end
            ACT_DIG: begin
                if (ground_s && (dig_q == DIG_LAST)) begin
                    dig_d     = '0;
                    dig_inc_s = 1'b1;
                end else if (ground_s) begin
                    dig_d     = dig_q + 1'b1;
                    dig_inc_s = 1'b0;
                end else begin
                    dig_d     = '0;
                    dig_inc_s = 1'b0;
                end
            end
            ACT_LEFT: begin
                if (ground_s && !blocked_left_s) begin
                    pos_d = pos_q - 1'b1;
                end else begin
                    pos_d = pos_q;
                end
            end
            ACT_RIGHT: begin
                if (ground_s && !blocked_right_s) begin
                    pos_d = pos_q + 1'b1;
                end else begin
                    pos_d = pos_q;
                end
            end
            default: begin
                pos_d = pos_q;
            end
        endcase
    end

    // Lemming state registers; reset drops it back at the start column on top.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            pos_q <= POS_RESET;
            lvl_q <= '0;
            dig_q <= '0;
        end else begin
            pos_q <= pos_d;
            lvl_q <= lvl_d;
            dig_q <= dig_d;
        end
    end

    assign ground     = ground_s;
    assign bump_left  = walk_left  & blocked_left_s;
    assign bump_right = walk_right & blocked_right_s;
    assign pos        = pos_q;
    assign lvl        = lvl_q;

endmodule

// File: tb/tb_lemming_world.sv
// Table-driven bench for lemming_world with a queue-based scoreboard.
module tb_lemming_world;
    import lemming_pkg::*;

    localparam int          OBS_W  = POS_W + LVL_W + 3;
    localparam logic [3:0]  I_NONE = 4'b0000;
    localparam logic [3:0]  I_WL   = 4'b1000;
    localparam logic [3:0]  I_WR   = 4'b0100;
    localparam logic [3:0]  I_AA   = 4'b0010;
    localparam logic [3:0]  I_DG   = 4'b0001;

    typedef logic [OBS_W-1:0] obs_t;

    typedef struct {
        string            name;
        logic             is_rst;
        logic [3:0]       in;
        logic             we;
        logic [POS_W-1:0] col;
        logic [LVL_W-1:0] dep;
        obs_t             exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             areset_n = 1'b1;
    logic             walk_left = 1'b0, walk_right = 1'b0, aaah = 1'b0, digging = 1'b0;
    logic             cfg_we = 1'b0;
    logic [POS_W-1:0] cfg_col = '0;
    logic [LVL_W-1:0] cfg_depth = '0;
    logic             bump_left, bump_right, ground;
    logic [POS_W-1:0] pos;
    logic [LVL_W-1:0] lvl;

    vec_t vecs[$];
    obs_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    lemming_world dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .walk_left  (walk_left),
        .walk_right (walk_right),
        .aaah       (aaah),
        .digging    (digging),
        .cfg_we     (cfg_we),
        .cfg_col    (cfg_col),
        .cfg_depth  (cfg_depth),
        .bump_left  (bump_left),
        .bump_right (bump_right),
        .ground     (ground),
        .pos        (pos),
        .lvl        (lvl)
    );

    function automatic obs_t pack_obs(logic g, logic bl, logic br, int p, int l);
        return {g, bl, br, POS_W'(p), LVL_W'(l)};
    endfunction

    function automatic vec_t mk(string nm, logic [3:0] in, logic we, int col, int dep,
                                logic g, logic bl, logic br, int p, int l);
        vec_t v;
        v.name   = nm;
        v.is_rst = 1'b0;
        v.in     = in;
        v.we     = we;
        v.col    = POS_W'(col);
        v.dep    = LVL_W'(dep);
        v.exp    = pack_obs(g, bl, br, p, l);
        return v;
    endfunction

    function automatic vec_t mk_rst(string nm);
        vec_t v;
        v        = mk(nm, I_NONE, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, START_POS, 0);
        v.is_rst = 1'b1;
        return v;
    endfunction

    task automatic drive_idle();
        {walk_left, walk_right, aaah, digging} = I_NONE;
        cfg_we    = 1'b0;
        cfg_col   = '0;
        cfg_depth = '0;
    endtask

    task automatic check_head(string nm);
        obs_t got;
        obs_t want;
        got = {ground, bump_left, bump_right, pos, lvl};
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty, got g=%0d bl=%0d br=%0d pos=%0d lvl=%0d",
                     nm, ground, bump_left, bump_right, pos, lvl);
        end else begin
            want = exp_q.pop_front();
            if (got === want) begin
                passed++;
            end else begin
                $display("FAIL %s: got g=%0d bl=%0d br=%0d pos=%0d lvl=%0d, want g=%0d bl=%0d br=%0d pos=%0d lvl=%0d",
                         nm, ground, bump_left, bump_right, pos, lvl,
                         want[OBS_W-1], want[OBS_W-2], want[OBS_W-3],
                         want[LVL_W +: POS_W], want[LVL_W-1:0]);
            end
        end
    endtask

    task automatic apply(vec_t v);
        @(negedge clk);
        {walk_left, walk_right, aaah, digging} = v.in;
        cfg_we    = v.we;
        cfg_col   = v.col;
        cfg_depth = v.dep;
        exp_q.push_back(v.exp);
        #1;
        check_head(v.name);
    endtask

    // Asynchronous reset between clock edges, checked before the next edge.
    task automatic do_reset(string nm);
        @(negedge clk);
        drive_idle();
        #2;
        areset_n = 1'b0;
        exp_q.push_back(pack_obs(1'b1, 1'b0, 1'b0, START_POS, 0));
        #1;
        check_head(nm);
        @(negedge clk);
        areset_n = 1'b1;
    endtask

    initial begin
        // Idle after reset release.
        for (int i = 0; i < 10; i++) vecs.push_back(mk("idle", I_NONE, 0, 0, 0, 1, 0, 0, 8, 0));
        // Walk right to the east wall.
        for (int p = 8; p <= 15; p++) vecs.push_back(mk("walk_r", I_WR, 0, 0, 0, 1, 0, (p == 15), p, 0));
        vecs.push_back(mk("walk_r_hold", I_WR, 0, 0, 0, 1, 0, 1, 15, 0));
        // Hole at column 5, fall in, wall checks.
        vecs.push_back(mk_rst("rst_hole"));
        vecs.push_back(mk("cfg5", I_NONE, 1, 5, 3, 1, 0, 0, 8, 0));
        for (int p = 8; p >= 6; p--) vecs.push_back(mk("walk_l", I_WL, 0, 0, 0, 1, 0, 0, p, 0));
        vecs.push_back(mk("hole_air", I_NONE, 0, 0, 0, 0, 0, 0, 5, 0));
        for (int l = 0; l <= 2; l++) vecs.push_back(mk("fall3", I_AA, 0, 0, 0, 0, 0, 0, 5, l));
        vecs.push_back(mk("land3", I_AA, 0, 0, 0, 1, 0, 0, 5, 3));
        vecs.push_back(mk("bump_l", I_WL, 0, 0, 0, 1, 1, 0, 5, 3));
        vecs.push_back(mk("bump_l_hold", I_WL, 0, 0, 0, 1, 1, 0, 5, 3));
        vecs.push_back(mk("bump_r", I_WR, 0, 0, 0, 1, 0, 1, 5, 3));
        // Burying write ignored, then config beats dig completion.
        vecs.push_back(mk("bury", I_NONE, 1, 5, 1, 1, 0, 0, 5, 3));
        vecs.push_back(mk("bury_chk", I_NONE, 0, 0, 0, 1, 0, 0, 5, 3));
        for (int i = 0; i < 3; i++) vecs.push_back(mk("dig5", I_DG, 0, 0, 0, 1, 0, 0, 5, 3));
        vecs.push_back(mk("dig5_cfg", I_DG, 1, 5, 6, 1, 0, 0, 5, 3));
        vecs.push_back(mk("cfg_wins", I_NONE, 0, 0, 0, 0, 0, 0, 5, 3));
        for (int l = 3; l <= 5; l++) vecs.push_back(mk("fall6", I_AA, 0, 0, 0, 0, 0, 0, 5, l));
        vecs.push_back(mk("land6", I_AA, 0, 0, 0, 1, 0, 0, 5, 6));
        // Dig at start column, then interrupted dig.
        vecs.push_back(mk_rst("rst_dig"));
        for (int i = 0; i < 4; i++) vecs.push_back(mk("dig8", I_DG, 0, 0, 0, 1, 0, 0, 8, 0));
        vecs.push_back(mk("dig8_done", I_DG, 0, 0, 0, 0, 0, 0, 8, 0));
        vecs.push_back(mk("fall1", I_AA, 0, 0, 0, 0, 0, 0, 8, 0));
        vecs.push_back(mk("land1", I_NONE, 0, 0, 0, 1, 0, 0, 8, 1));
        for (int i = 0; i < 2; i++) vecs.push_back(mk("dig_pre", I_DG, 0, 0, 0, 1, 0, 0, 8, 1));
        vecs.push_back(mk("dig_gap", I_NONE, 0, 0, 0, 1, 0, 0, 8, 1));
        for (int i = 0; i < 4; i++) vecs.push_back(mk("dig_post", I_DG, 0, 0, 0, 1, 0, 0, 8, 1));
        vecs.push_back(mk("dig_restart", I_NONE, 0, 0, 0, 0, 0, 0, 8, 1));
        // West wall and input priority.
        vecs.push_back(mk_rst("rst_edge"));
        for (int p = 8; p >= 1; p--) vecs.push_back(mk("walk_l_edge", I_WL, 0, 0, 0, 1, 0, 0, p, 0));
        vecs.push_back(mk("bump_l_edge", I_WL, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk("bump_l_edge2", I_WL, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk("prio_all", 4'b1111, 0, 0, 0, 1, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk("prio_dig", I_DG | I_WR, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("prio_dig_done", I_NONE, 0, 0, 0, 0, 0, 0, 0, 0));
        // Bedrock cannot be dug.
        vecs.push_back(mk_rst("rst_bed"));
        vecs.push_back(mk("cfg8_bed", I_NONE, 1, 8, 7, 1, 0, 0, 8, 0));
        for (int l = 0; l <= 6; l++) vecs.push_back(mk("fall_bed", I_AA, 0, 0, 0, 0, 0, 0, 8, l));
        vecs.push_back(mk("land_bed", I_AA, 0, 0, 0, 1, 0, 0, 8, 7));
        for (int i = 0; i < 12; i++) vecs.push_back(mk("dig_bed", I_DG, 0, 0, 0, 1, 0, 0, 8, 7));
        vecs.push_back(mk("bed_hold", I_NONE, 0, 0, 0, 1, 0, 0, 8, 7));

        // Power-on reset check.
        drive_idle();
        #1 areset_n = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.push_back(pack_obs(1'b1, 1'b0, 1'b0, START_POS, 0));
        #1;
        check_head("reset_hold");
        @(negedge clk);
        areset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_rst) do_reset(vecs[i].name);
            else apply(vecs[i]);
        end

        // Reset mid-fall discards level and terrain.
        do_reset("rst_pre_fall");
        apply(mk("cfg8_5", I_NONE, 1, 8, 5, 1, 0, 0, 8, 0));
        apply(mk("fall_mid", I_AA, 0, 0, 0, 0, 0, 0, 8, 0));
        apply(mk("fall_mid", I_AA, 0, 0, 0, 0, 0, 0, 8, 1));
        do_reset("rst_mid_fall");
        apply(mk("flat_after_rst", I_NONE, 0, 0, 0, 1, 0, 0, 8, 0));
        // Reset mid-dig discards dig progress.
        for (int i = 0; i < 3; i++) apply(mk("dig_mid", I_DG, 0, 0, 0, 1, 0, 0, 8, 0));
        do_reset("rst_mid_dig");
        for (int i = 0; i < 4; i++) apply(mk("dig_fresh", I_DG, 0, 0, 0, 1, 0, 0, 8, 0));
        apply(mk("dig_fresh_done", I_NONE, 0, 0, 0, 0, 0, 0, 8, 0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
